// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C slave responder.
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  localparam int I2C_CNT_W  = 4;

  typedef enum logic {
    I2C_WRITE = 1'b0,
    I2C_READ  = 1'b1
  } i2c_op_t;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } i2c_state_t;
endpackage

// File: rtl/i2c_slave_responder_if.sv
// Bus lines plus user-side byte handshake of the I2C slave responder.
interface i2c_slave_responder_if import i2c_pkg::*; #(
  parameter int DW = I2C_DATA_W
) ();
  logic          scl_i;
  logic          sda_i;
  logic          sda_o;
  logic          wr_valid_o;
  logic [DW-1:0] wr_data_o;
  logic          rd_req_o;
  logic [DW-1:0] rd_data_i;
  logic          busy_o;
  logic          op_o;

  modport slave (
    input  scl_i, sda_i, rd_data_i,
    output sda_o, wr_valid_o, wr_data_o, rd_req_o, busy_o, op_o
  );
  modport master (
    output scl_i, sda_i, rd_data_i,
    input  sda_o, wr_valid_o, wr_data_o, rd_req_o, busy_o, op_o
  );
endinterface

// File: rtl/i2c_line_sync.sv
// 2-flop synchronizer, 3-sample majority glitch filter and edge detect for one bus line.
// Filtered level lags the pin by about four clk_i cycles; edges are one-cycle strobes.
module i2c_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [1:0] sync_q;
  logic [2:0] hist_q;
  logic       filt_q;
  logic       maj;

  assign maj = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync_q <= 2'b11;
      hist_q <= 3'b111;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line_i};
      hist_q <= {hist_q[1:0], sync_q[1]};
      filt_q <= maj;
    end
  end

  assign level_o = maj;
  assign rise_o  = maj & ~filt_q;
  assign fall_o  = ~maj & filt_q;
endmodule

// File: rtl/i2c_slave_responder.sv
// Byte-level I2C slave: ACKs its own address, emits received write bytes, fetches read bytes.
// sda_o moves one clk_i after each filtered SCL fall; no clock stretching, so rd_data_i must be valid by the next SCL fall.
module i2c_slave_responder import i2c_pkg::*; #(
  parameter int                        I2C_ADDR_WIDTH = I2C_ADDR_W,
  parameter int                        I2C_DATA_WIDTH = I2C_DATA_W,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22
) (
  input logic                  clk_i,
  input logic                  rst_i,
  i2c_slave_responder_if.slave bus
);
  localparam logic [I2C_CNT_W-1:0] ADDR_LAST = I2C_CNT_W'(I2C_ADDR_WIDTH);
  localparam logic [I2C_CNT_W-1:0] DATA_LAST = I2C_CNT_W'(I2C_DATA_WIDTH - 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_state_t                state_q, state_d;
  logic [I2C_CNT_W-1:0]      cnt_q, cnt_d;
  logic [I2C_DATA_WIDTH-1:0] shreg_q, shreg_d, wr_data_q, wr_data_d, nb;
  logic                      sda_q, sda_d, wr_valid_q, wr_valid_d, rd_req_q, rd_req_d, busy_q, busy_d;
  i2c_op_t                   op_q, op_d;

  i2c_line_sync u_scl_sync (.clk_i(clk_i), .rst_i(rst_i), .line_i(bus.scl_i),
                            .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));
  i2c_line_sync u_sda_sync (.clk_i(clk_i), .rst_i(rst_i), .line_i(bus.sda_i),
                            .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign nb        = {shreg_q[I2C_DATA_WIDTH-2:0], sda_lvl};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    sda_d      = sda_q;
    wr_valid_d = 1'b0;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    busy_d     = busy_q;
    op_d       = op_q;
    if (start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
      shreg_d = '0;
      sda_d   = 1'b1;
    end else if (stop_det) begin
      state_d = IDLE;
      cnt_d   = '0;
      shreg_d = '0;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: if (scl_rise) begin
          shreg_d = nb;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            shreg_d = '0;
            if (nb[I2C_ADDR_WIDTH:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              op_d    = i2c_op_t'(nb[0]);
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        // cnt 0: ACK slot not yet clocked; cnt 1: ACK clocked, leave on the next fall
        ADDR_ACK, WR_ACK: begin
          if (scl_fall && cnt_q == '0) begin
            sda_d = 1'b0;
          end else if (scl_rise) begin
            cnt_d    = 4'd1;
            rd_req_d = (state_q == ADDR_ACK) && (op_q == I2C_READ);
          end else if (scl_fall) begin
            cnt_d = '0;
            if (state_q == ADDR_ACK && op_q == I2C_READ) begin
              state_d = RD_DATA;
              shreg_d = bus.rd_data_i;
              sda_d   = bus.rd_data_i[I2C_DATA_WIDTH-1];
            end else begin
              state_d = WR_DATA;
              sda_d   = 1'b1;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shreg_d = nb;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == DATA_LAST) begin
            wr_data_d  = nb;
            wr_valid_d = 1'b1;
            state_d    = WR_ACK;
            cnt_d      = '0;
            shreg_d    = '0;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DATA_LAST) begin
              state_d = RD_ACK;
              cnt_d   = '0;
            end
          end else if (scl_fall) begin
            shreg_d = shreg_q << 1;
            sda_d   = shreg_q[I2C_DATA_WIDTH-2];
          end
        end
        RD_ACK: begin
          if (scl_fall && cnt_q == '0) begin
            sda_d = 1'b1;
          end else if (scl_rise) begin
            if (!sda_lvl) begin
              rd_req_d = 1'b1;
              cnt_d    = 4'd1;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall) begin
            state_d = RD_DATA;
            cnt_d   = '0;
            shreg_d = bus.rd_data_i;
            sda_d   = bus.rd_data_i[I2C_DATA_WIDTH-1];
          end
        end
        default: sda_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      sda_q      <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      op_q       <= I2C_WRITE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      sda_q      <= sda_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      busy_q     <= busy_d;
      op_q       <= op_d;
    end
  end

  assign bus.sda_o      = sda_q;
  assign bus.wr_valid_o = wr_valid_q;
  assign bus.wr_data_o  = wr_data_q;
  assign bus.rd_req_o   = rd_req_q;
  assign bus.busy_o     = busy_q;
  assign bus.op_o       = op_q;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench: bit-banged I2C master on a wired-AND SDA, transaction-level expectations from the address/ACK rules.
module tb_i2c_slave_responder;
  import i2c_pkg::*;

  localparam int         Q     = 8;
  localparam logic [6:0] SLAVE = 7'h22;
  typedef logic [7:0] bq_t[$];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  int  vec_cnt = 0, err_cnt = 0;
  int  rd_req_cnt = 0, sda_low_cnt = 0, exp_rdreq = 0;
  bit  busy_seen = 1'b0, exp_busy_seen = 1'b0;
  bq_t wr_got, exp_wr, rd_src;

  always #5 clk = ~clk;

  i2c_slave_responder_if bus ();
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & bus.sda_o;

  i2c_slave_responder #(.SLAVE_ADDR(SLAVE)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    tick(Q); sda_m = b; tick(Q); scl_m = 1'b1; tick(2*Q); scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    tick(Q); sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); b = bus.sda_i; tick(Q); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic bus_start();
    sda_m = 1'b0; tick(Q); scl_m = 1'b0;
  endtask

  task automatic rep_start();
    tick(Q); sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(2*Q);
  endtask

  // Address byte then data bytes; the slave ACKs everything only when the address is its own.
  task automatic write_phase(input logic [6:0] a, input bq_t d);
    logic ack;
    bit   hit;
    hit = (a == SLAVE);
    write_byte({a, 1'b0}, ack);
    check_val("addr_ack_w", ack, hit);
    check_val("busy_after_addr_w", bus.busy_o, hit);
    if (hit) begin
      check_val("op_w", bus.op_o, I2C_WRITE);
      exp_busy_seen = 1'b1;
    end
    foreach (d[i]) begin
      write_byte(d[i], ack);
      check_val("data_ack", ack, hit);
      if (hit) exp_wr.push_back(d[i]);
    end
  endtask

  // Master reads d.size() bytes, ACKing all but the last; one rd_req per byte fetched.
  task automatic read_phase(input logic [6:0] a, input bq_t d);
    logic       ack;
    logic [7:0] got;
    bit         hit;
    hit = (a == SLAVE);
    if (hit) begin
      foreach (d[i]) rd_src.push_back(d[i]);
      exp_rdreq += d.size();
    end
    write_byte({a, 1'b1}, ack);
    check_val("addr_ack_r", ack, hit);
    check_val("busy_after_addr_r", bus.busy_o, hit);
    if (hit) begin
      check_val("op_r", bus.op_o, I2C_READ);
      exp_busy_seen = 1'b1;
      foreach (d[i]) begin
        read_byte(got, i == d.size() - 1);
        check_val("rd_byte", got, d[i]);
      end
      check_val("busy_after_nack", bus.busy_o, 1'b0);
      check_val("state_ignore", dut.state_q, IGNORE);
    end
  endtask

  task automatic end_checks();
    check_val("wr_count", wr_got.size(), exp_wr.size());
    foreach (exp_wr[i])
      if (i < wr_got.size()) check_val("wr_byte", wr_got[i], exp_wr[i]);
    check_val("rd_req_count", rd_req_cnt, exp_rdreq);
    check_val("rd_src_drained", rd_src.size(), 0);
    check_val("busy_end", bus.busy_o, 1'b0);
    check_val("busy_seen", busy_seen, exp_busy_seen);
    check_val("state_idle", dut.state_q, IDLE);
    wr_got.delete(); exp_wr.delete(); rd_src.delete();
    rd_req_cnt = 0; exp_rdreq = 0; busy_seen = 1'b0; exp_busy_seen = 1'b0;
  endtask

  initial begin
    bus.rd_data_i = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.wr_valid_o) wr_got.push_back(bus.wr_data_o);
      if (bus.rd_req_o) begin
        rd_req_cnt++;
        if (rd_src.size() > 0) bus.rd_data_i = rd_src.pop_front();
        else bus.rd_data_i = 8'hFF;
      end
      if (bus.sda_o === 1'b0) sda_low_cnt++;
      if (bus.busy_o === 1'b1) busy_seen = 1'b1;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, %0d vectors applied", vec_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack, b;
    bq_t        d;
    logic [6:0] a;
    int         n;

    tick(5);
    check_val("rst_sda", bus.sda_o, 1'b1);
    check_val("rst_busy", bus.busy_o, 1'b0);
    check_val("rst_wr_valid", bus.wr_valid_o, 1'b0);
    check_val("rst_rd_req", bus.rd_req_o, 1'b0);
    check_val("rst_op", bus.op_o, 1'b0);
    check_val("rst_wr_data", bus.wr_data_o, 8'h00);
    check_val("rst_state", dut.state_q, IDLE);
    rst_n = 1'b1;
    tick(5);
    end_checks();

    // write 0x44, 0x78 to own address
    d.delete(); d.push_back(8'h44); d.push_back(8'h78);
    bus_start(); write_phase(SLAVE, d); bus_stop(); end_checks();

    // foreign address: never drives SDA
    sda_low_cnt = 0;
    d.delete(); d.push_back(8'h5A);
    bus_start(); write_phase(7'h23, d); bus_stop();
    check_val("foreign_sda_low", sda_low_cnt, 0);
    end_checks();

    // read 0xA5 (ACK) then 0x3C (NACK)
    d.delete(); d.push_back(8'hA5); d.push_back(8'h3C);
    bus_start(); read_phase(SLAVE, d); bus_stop(); end_checks();

    // write 0x11, repeated START, read one byte
    d.delete(); d.push_back(8'h11);
    bus_start(); write_phase(SLAVE, d);
    d.delete(); d.push_back(8'($urandom_range(0, 255)));
    rep_start(); read_phase(SLAVE, d); bus_stop(); end_checks();

    // STOP after four data bits: partial byte dropped
    exp_busy_seen = 1'b1;
    bus_start(); write_byte({SLAVE, 1'b0}, ack);
    check_val("partial_addr_ack", ack, 1'b1);
    repeat (4) send_bit(1'($urandom_range(0, 1)));
    bus_stop(); end_checks();

    // reset while driving a 0 data bit; bus ignored afterwards
    rd_src.push_back(8'h00); exp_rdreq = 1; exp_busy_seen = 1'b1;
    bus_start(); write_byte({SLAVE, 1'b1}, ack);
    check_val("rst_test_addr_ack", ack, 1'b1);
    repeat (3) recv_bit(b);
    tick(Q);
    check_val("rd_bit_driven", bus.sda_o, 1'b0);
    rst_n = 1'b0;
    tick(1);
    check_val("sda_rel_on_rst", bus.sda_o, 1'b1);
    check_val("state_on_rst", dut.state_q, IDLE);
    check_val("busy_on_rst", bus.busy_o, 1'b0);
    rst_n = 1'b1;
    sda_low_cnt = 0;
    tick(Q); scl_m = 1'b1; tick(2*Q); scl_m = 1'b0;
    repeat (4) recv_bit(b);
    send_bit(1'b1);
    check_val("ignored_after_rst", sda_low_cnt, 0);
    bus_stop(); end_checks();

    for (int t = 0; t < 14; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLAVE;
      n = $urandom_range(1, 3);
      d.delete();
      for (int k = 0; k < n; k++) d.push_back(8'($urandom_range(0, 255)));
      bus_start();
      if ($urandom_range(0, 1) == 1) read_phase(a, d);
      else write_phase(a, d);
      bus_stop();
      end_checks();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/i2c_slave_responder.md
I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 SHALL have parameter I2C_ADDR_WIDTH, default 7, slave address width.
REQ-002 SHALL have parameter I2C_DATA_WIDTH, default 8, data byte width.
REQ-003 SHALL have parameter SLAVE_ADDR, default 7'h22, address this block responds to.
REQ-004 SHALL have port clk_i  in  1  system clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port scl_i  in  1  I2C clock from bus, asynchronous.
REQ-007 SHALL have port sda_i  in  1  I2C data from bus, asynchronous.
REQ-008 SHALL have port sda_o  out  1  open-drain data drive: 0 pulls low, 1 releases.
REQ-009 SHALL have port wr_valid_o  out  1  one-cycle pulse, received write byte on wr_data_o.
REQ-010 SHALL have port wr_data_o  out  I2C_DATA_WIDTH  last received write byte.
REQ-011 SHALL have port rd_req_o  out  1  one-cycle pulse requesting next read byte.
REQ-012 SHALL have port rd_data_i  in  I2C_DATA_WIDTH  read byte supplied by user logic.
REQ-013 SHALL have port busy_o  out  1  high from addressed START to STOP or NACK.
REQ-014 SHALL have port op_o  out  1  direction of current transfer: 0 write, 1 read.

Function
REQ-015 SHALL pass scl_i/sda_i through 2-flop synchronizer plus 3-sample majority filter; every event below refers to the filtered signals.
REQ-016 SHALL detect START as SDA falling while SCL high, and STOP as SDA rising while SCL high.
REQ-017 SHALL sample SDA on SCL rising edge; SHALL change sda_o exactly 1 clk_i after detected SCL falling edge.
REQ-018 SHALL implement FSM states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-019 IDLE -> ADDR on START; ADDR shifts 8 bits MSB first (7 address + R/W).
REQ-020 ADDR -> ADDR_ACK if address equals SLAVE_ADDR; else -> IGNORE with sda_o held 1.
REQ-021 ADDR_ACK SHALL drive sda_o=0 for the ninth SCL period, latch op_o, set busy_o; then -> WR_DATA (op 0) or RD_DATA (op 1).
REQ-022 WR_DATA SHALL shift 8 bits; on eighth SCL rising edge SHALL update wr_data_o and pulse wr_valid_o; -> WR_ACK, drive ACK (sda_o=0), then -> WR_DATA.
REQ-023 rd_req_o SHALL pulse on the SCL rising edge of the address ACK and of each master ACK; rd_data_i SHALL be latched on the following SCL falling edge and shifted out MSB first in RD_DATA.
REQ-024 RD_ACK SHALL release sda_o and sample master bit: 0 -> RD_DATA (next byte), 1 (NACK) -> IGNORE, busy_o cleared.
REQ-025 START detected in any state (repeated START) SHALL abort the current byte, discard partial bits without wr_valid_o, and -> ADDR.
REQ-026 STOP detected in any state SHALL -> IDLE, release sda_o, clear busy_o; partial byte discarded.
REQ-027 IGNORE SHALL keep sda_o=1 and wait for START or STOP.
REQ-028 Bit counter SHALL be 4 bits, reset to 0 on every byte boundary, START and STOP.
REQ-029 sda_o SHALL never be 0 outside ADDR_ACK, WR_ACK, or a 0 data bit in RD_DATA.

Reset
REQ-030 While rst_i=0 at a clk_i edge: state IDLE, sda_o=1, wr_valid_o=0, wr_data_o=0, rd_req_o=0, busy_o=0, op_o=0, shift registers and counter 0, synchronizers set to 1.
REQ-031 Reset mid-transfer SHALL release sda_o in the same cycle and ignore the bus until next START.

Structure
REQ-032 Package i2c_pkg SHALL hold i2c_op_t (I2C_WRITE=0, I2C_READ=1), the FSM state enum, and width constants.
REQ-033 Sub-module i2c_line_sync SHALL implement synchronizer, filter and rise/fall detect; instantiated once for SCL and once for SDA.
REQ-034 clk_i SHALL be at least 16x SCL frequency; 100 kHz and 400 kHz with 100 MHz clk_i supported.

Verification
REQ-035 Write to 0x22, bytes 0x44, 0x78, STOP -> ACK on all three, wr_valid_o pulses twice with 0x44 then 0x78, busy_o low after STOP.
REQ-036 Address 0x23 write -> sda_o stays 1 throughout, no wr_valid_o, busy_o stays 0.
REQ-037 Read from 0x22, rd_data_i=0xA5 then 0x3C, master ACK then NACK -> bus shows 0xA5, 0x3C; rd_req_o pulses twice; IGNORE after NACK.
REQ-038 Write 0x11, repeated START, read from 0x22 -> wr_valid_o with 0x11, op_o switches to 1, read byte delivered.
REQ-039 STOP after 4 data bits, and rst_i=0 during RD_DATA -> no wr_valid_o, sda_o=1 within 1 clk_i, state IDLE.
